// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Takes instructions from the fetch stage over a valid/ready handshake.
//   It decodes the opcode and function fields into an ALU operation code
//   and offers that code to the ALU over a second valid/ready handshake.
//   While a multi-cycle ALU operation (codes 12..14) executes, it holds
//   off new instructions. It flags illegal encodings and keeps a
//   saturating count of them.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   instr_valid  in   upstream has an instruction
//   instr_ready  out  block can accept an instruction (IDLE and not in reset)
//   instr        in   instruction word [INSTR_W-1:0]
//   op_valid     out  alu_op is valid for the ALU
//   op_ready     in   ALU accepts alu_op
//   alu_op       out  decoded ALU operation code [OP_W-1:0]
//   mc_busy      out  a multi-cycle operation is executing
//   illegal      out  one-cycle pulse after an illegal instruction is accepted
//   ill_count    out  saturating count of illegal instructions [ILL_CNT_W-1:0]
module alu_op_sequencer #(
    parameter int INSTR_W   = 16,
    parameter int FUNC_W    = 8,
    parameter int OP_W      = 5,
    parameter int MC_CYCLES = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [OP_W-1:0]      alu_op,
    output logic                 mc_busy,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    // The function field is compared at a width of at least 8 bits.
    // This keeps a narrow field from aliasing onto the 8-bit code points.
    localparam int FX = (FUNC_W > 8) ? FUNC_W : 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [OP_W-1:0]      alu_op_n;
    logic                 op_valid_n;
    logic                 mc_busy_n;
    logic                 illegal_n;
    logic [ILL_CNT_W-1:0] ill_count_n;
    logic [7:0]           cnt, cnt_n;

    logic [3:0]           op4;
    logic [FX-1:0]        fx;
    logic [5:0]           dec;
    logic                 dec_legal;
    logic [4:0]           dec_code;

    // Bits between the opcode and function fields are don't-care.
    logic                 unused_instr;
    assign unused_instr = ^instr;

    // Returns {legal, code[4:0]}.
    function automatic logic [5:0] decode(input logic [3:0] o, input logic [FX-1:0] f);
        logic [5:0] r;
        r = 6'd0;
        case (o)
            4'b0000: r = {1'b1, 5'd0};
            4'b0001: r = {1'b1, 5'd1};
            4'b0010: r = {1'b1, 5'd2};
            4'b0100: r = {1'b1, 5'd3};
            4'b1000: begin
                case (f)
                    FX'(8'h01): r = {1'b1, 5'd4};
                    FX'(8'h02): r = {1'b1, 5'd5};
                    FX'(8'h04): r = {1'b1, 5'd6};
                    FX'(8'h08): r = {1'b1, 5'd7};
                    FX'(8'h10): r = {1'b1, 5'd8};
                    FX'(8'h20): r = {1'b1, 5'd9};
                    FX'(8'h40): r = {1'b1, 5'd10};
                    FX'(8'h80): r = {1'b1, 5'd11};
                    FX'(8'h81): r = {1'b1, 5'd12};
                    FX'(8'h82): r = {1'b1, 5'd13};
                    FX'(8'h83): r = {1'b1, 5'd14};
                    default:    r = 6'd0;
                endcase
            end
            4'b1100: r = {1'b1, 5'd15};
            4'b1101: r = {1'b1, 5'd16};
            4'b1110: r = {1'b1, 5'd17};
            4'b1111: r = {1'b1, 5'd18};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_multi(input logic [OP_W-1:0] op);
        return (op == OP_W'(12)) || (op == OP_W'(13)) || (op == OP_W'(14));
    endfunction

    assign op4       = instr[INSTR_W-1 -: 4];
    assign fx        = FX'(instr[FUNC_W-1:0]);
    assign dec       = decode(op4, fx);
    assign dec_legal = dec[5];
    assign dec_code  = dec[4:0];

    // Depends only on state and reset, never on instr_valid.
    assign instr_ready = (state == IDLE) && !rst;

    always_comb begin
        state_n     = state;
        alu_op_n    = alu_op;
        op_valid_n  = op_valid;
        mc_busy_n   = mc_busy;
        illegal_n   = 1'b0;
        ill_count_n = ill_count;
        cnt_n       = cnt;

        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (dec_legal) begin
                        alu_op_n   = OP_W'(dec_code);
                        op_valid_n = 1'b1;
                        state_n    = ISSUE;
                    end else begin
                        illegal_n = 1'b1;
                        if (ill_count != {ILL_CNT_W{1'b1}})
                            ill_count_n = ill_count + ILL_CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    op_valid_n = 1'b0;
                    if (is_multi(alu_op)) begin
                        // The handshake cycle is the first ALU cycle, so
                        // MC_CYCLES-1 busy cycles remain.
                        mc_busy_n = 1'b1;
                        cnt_n     = 8'(MC_CYCLES - 1);
                        state_n   = WAIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            WAIT: begin
                if (cnt == 8'd1) begin
                    mc_busy_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n    = IDLE;
                op_valid_n = 1'b0;
                mc_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_op    <= '0;
            op_valid  <= 1'b0;
            mc_busy   <= 1'b0;
            illegal   <= 1'b0;
            ill_count <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            alu_op    <= alu_op_n;
            op_valid  <= op_valid_n;
            mc_busy   <= mc_busy_n;
            illegal   <= illegal_n;
            ill_count <= ill_count_n;
            cnt       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int INSTR_W   = 16;
    localparam int FUNC_W    = 8;
    localparam int OP_W      = 5;
    localparam int MC_CYCLES = 4;
    localparam int ILL_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic                 op_valid;
    logic                 op_ready;
    logic [OP_W-1:0]      alu_op;
    logic                 mc_busy;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    int errors = 0;
    int checks = 0;
    int exp_ill = 0;

    alu_op_sequencer #(
        .INSTR_W(INSTR_W), .FUNC_W(FUNC_W), .OP_W(OP_W),
        .MC_CYCLES(MC_CYCLES), .ILL_CNT_W(ILL_CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .op_valid(op_valid), .op_ready(op_ready), .alu_op(alu_op),
        .mc_busy(mc_busy), .illegal(illegal), .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        legal;
        logic [4:0]  op;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{16'h0000, 1'b1, 5'd0});
        vecs.push_back('{16'h1000, 1'b1, 5'd1});
        vecs.push_back('{16'h2ABC, 1'b1, 5'd2});
        vecs.push_back('{16'h4FFF, 1'b1, 5'd3});
        vecs.push_back('{16'h8001, 1'b1, 5'd4});
        vecs.push_back('{16'h8002, 1'b1, 5'd5});
        vecs.push_back('{16'h8004, 1'b1, 5'd6});
        vecs.push_back('{16'h8008, 1'b1, 5'd7});
        vecs.push_back('{16'h8010, 1'b1, 5'd8});
        vecs.push_back('{16'h8020, 1'b1, 5'd9});
        vecs.push_back('{16'h8040, 1'b1, 5'd10});
        vecs.push_back('{16'h8080, 1'b1, 5'd11});
        vecs.push_back('{16'h8081, 1'b1, 5'd12});
        vecs.push_back('{16'h8F82, 1'b1, 5'd13});
        vecs.push_back('{16'h8083, 1'b1, 5'd14});
        vecs.push_back('{16'hC000, 1'b1, 5'd15});
        vecs.push_back('{16'hD555, 1'b1, 5'd16});
        vecs.push_back('{16'hE0F0, 1'b1, 5'd17});
        vecs.push_back('{16'hF123, 1'b1, 5'd18});
        vecs.push_back('{16'h3000, 1'b0, 5'd0});
        vecs.push_back('{16'h5000, 1'b0, 5'd0});
        vecs.push_back('{16'h6001, 1'b0, 5'd0});
        vecs.push_back('{16'h7000, 1'b0, 5'd0});
        vecs.push_back('{16'h9001, 1'b0, 5'd0});
        vecs.push_back('{16'hA000, 1'b0, 5'd0});
        vecs.push_back('{16'hB080, 1'b0, 5'd0});
        vecs.push_back('{16'h8003, 1'b0, 5'd0});
        vecs.push_back('{16'h8000, 1'b0, 5'd0});
        vecs.push_back('{16'h8084, 1'b0, 5'd0});
        vecs.push_back('{16'h80FF, 1'b0, 5'd0});

        rst = 1'b1; instr_valid = 1'b0; instr = '0; op_ready = 1'b1;
        step(); step();
        chk("rst_instr_ready", instr_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_mc_busy", mc_busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ill_count", ill_count, 0);
        rst = 1'b0;
        #1;
        chk("rel_instr_ready", instr_ready, 1);
        step();

        // Each vector on its own, starting in IDLE with op_ready high.
        foreach (vecs[i]) begin
            logic [OP_W-1:0] prev_op;
            prev_op = alu_op;
            op_ready = 1'b1;
            instr = vecs[i].instr;
            instr_valid = 1'b1;
            step();
            instr_valid = 1'b0;
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_op_valid", i), op_valid, 1);
                chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
                chk($sformatf("v%0d_illegal", i), illegal, 0);
                chk($sformatf("v%0d_ready_lo", i), instr_ready, 0);
                step();
                chk($sformatf("v%0d_op_valid_drop", i), op_valid, 0);
                if (vecs[i].op >= 12 && vecs[i].op <= 14) begin
                    for (int k = 0; k < MC_CYCLES - 1; k++) begin
                        chk($sformatf("v%0d_mc_busy_c%0d", i, k), mc_busy, 1);
                        chk($sformatf("v%0d_ready_c%0d", i, k), instr_ready, 0);
                        step();
                    end
                end
                chk($sformatf("v%0d_mc_busy_end", i), mc_busy, 0);
                chk($sformatf("v%0d_ready_end", i), instr_ready, 1);
            end else begin
                exp_ill = sat_inc(exp_ill);
                chk($sformatf("v%0d_illegal", i), illegal, 1);
                chk($sformatf("v%0d_no_op_valid", i), op_valid, 0);
                chk($sformatf("v%0d_ill_count", i), ill_count, exp_ill);
                chk($sformatf("v%0d_alu_op_kept", i), alu_op, prev_op);
                step();
                chk($sformatf("v%0d_illegal_pulse", i), illegal, 0);
            end
        end

        // Multi-cycle op with the next instruction waiting; then backpressure.
        instr = 16'h8082; instr_valid = 1'b1; op_ready = 1'b1;
        step();
        chk("mc_alu_op", alu_op, 13);
        chk("mc_op_valid", op_valid, 1);
        instr = 16'h1000;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mc_busy_%0d", k), mc_busy, 1);
            chk($sformatf("mc_ready_lo_%0d", k), instr_ready, 0);
            chk($sformatf("mc_no_accept_%0d", k), op_valid, 0);
            step();
        end
        chk("mc_busy_fall", mc_busy, 0);
        chk("mc_ready_back", instr_ready, 1);
        chk("mc_not_yet", op_valid, 0);
        op_ready = 1'b0;
        step();
        instr_valid = 1'b0;
        chk("bp_accept_valid", op_valid, 1);
        chk("bp_accept_op", alu_op, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_hold_valid_%0d", k), op_valid, 1);
            chk($sformatf("bp_hold_op_%0d", k), alu_op, 1);
            chk($sformatf("bp_ready_lo_%0d", k), instr_ready, 0);
        end
        op_ready = 1'b1;
        step();
        chk("bp_release_valid", op_valid, 0);
        chk("bp_release_ready", instr_ready, 1);
        chk("bp_no_mc", mc_busy, 0);

        // Illegal then legal back to back.
        instr = 16'h3000; instr_valid = 1'b1;
        step();
        exp_ill = sat_inc(exp_ill);
        chk("b2b_illegal", illegal, 1);
        chk("b2b_ready", instr_ready, 1);
        instr = 16'h2ABC;
        step();
        instr_valid = 1'b0;
        chk("b2b_illegal_drop", illegal, 0);
        chk("b2b_op_valid", op_valid, 1);
        chk("b2b_alu_op", alu_op, 2);
        chk("b2b_ill_count", ill_count, exp_ill);
        step();
        chk("b2b_done", op_valid, 0);

        // Continuous illegal stream: 0x3000, 0x8003, then 257 more.
        instr_valid = 1'b1;
        for (int k = 0; k < 259; k++) begin
            instr = (k % 2 == 0) ? 16'h3000 : 16'h8003;
            step();
            exp_ill = sat_inc(exp_ill);
            chk($sformatf("sat_illegal_%0d", k), illegal, 1);
            chk($sformatf("sat_op_valid_%0d", k), op_valid, 0);
            chk($sformatf("sat_count_%0d", k), ill_count, exp_ill);
        end
        instr_valid = 1'b0;
        step();
        chk("sat_illegal_end", illegal, 0);
        chk("sat_count_final", ill_count, 255);

        // Asynchronous reset while in ISSUE.
        instr = 16'h8083; instr_valid = 1'b1; op_ready = 1'b0;
        step();
        instr_valid = 1'b0;
        chk("ar_pre_valid", op_valid, 1);
        chk("ar_pre_op", alu_op, 14);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_op_valid", op_valid, 0);
        chk("ar_alu_op", alu_op, 0);
        chk("ar_mc_busy", mc_busy, 0);
        chk("ar_ill_count", ill_count, 0);
        chk("ar_instr_ready", instr_ready, 0);
        step();
        rst = 1'b0;
        op_ready = 1'b1;
        #1;
        chk("ar_release_ready", instr_ready, 1);
        chk("ar_release_op_valid", op_valid, 0);
        step();
        chk("ar_idle_no_mc", mc_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
